// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants for the CNN layer scheduler (widths, bank selects, FSM states).
package cnn_pkg;

    localparam int DW    = 20;
    localparam int AW    = 12;
    localparam int IMG_W = 64;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0K0 = 3'b001;
    localparam logic [2:0] CSEL_L0K1 = 3'b010;
    localparam logic [2:0] CSEL_L1K0 = 3'b011;
    localparam logic [2:0] CSEL_L1K1 = 3'b100;
    localparam logic [2:0] CSEL_L2   = 3'b101;

    typedef logic [3:0] state_t;

    // RD0..RD3 are consecutive so the read phase is state - S_RD0.
    localparam state_t S_IDLE  = 4'd0;
    localparam state_t S_START = 4'd1;
    localparam state_t S_CONV  = 4'd2;
    localparam state_t S_RD0   = 4'd3;
    localparam state_t S_RD1   = 4'd4;
    localparam state_t S_RD2   = 4'd5;
    localparam state_t S_RD3   = 4'd6;
    localparam state_t S_WL1   = 4'd7;
    localparam state_t S_WL2   = 4'd8;
    localparam state_t S_DONE  = 4'd9;

endpackage

// File: rtl/cnn_pool_agu.sv
// cnn_pool_agu: combinational address generator for 2x2 pooling windows and layer-1/layer-2 writes.
module cnn_pool_agu #(
    parameter int AW    = 12,
    parameter int IMG_W = 64,
    parameter int KW    = 10
) (
    input  logic [KW-1:0] k,
    input  logic [1:0]    phase,
    input  logic          kern,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] l1_addr,
    output logic [AW-1:0] l2_addr
);

    localparam int PW = IMG_W / 2;

    int r;
    int c;

    always_comb begin
        r = int'(k) / PW;
        c = int'(k) % PW;
        rd_addr = AW'((2 * r + int'(phase[1])) * IMG_W + 2 * c + int'(phase[0]));
        l1_addr = AW'(k);
        l2_addr = AW'({k, kern});
    end

endmodule

// File: rtl/cnn_layer_sched.sv
// cnn_layer_sched: top sequencer; runs conv per kernel, then 2x2 max-pool writing layer 1 and
// the interleaved flatten layer 2 in one pass over the shared memory port.
module cnn_layer_sched #(
    parameter int DW    = cnn_pkg::DW,
    parameter int AW    = cnn_pkg::AW,
    parameter int IMG_W = cnn_pkg::IMG_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    output logic          conv_start,
    output logic          conv_kernel,
    input  logic          conv_done,
    input  logic          conv_wr_req,
    input  logic [AW-1:0] conv_wr_addr,
    input  logic [DW-1:0] conv_wr_data,
    output logic          conv_wr_gnt,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic [2:0]    csel
);

    import cnn_pkg::*;

    localparam int PW = IMG_W / 2;
    localparam int KW = $clog2(PW * PW);
    localparam logic [KW-1:0] LAST_K = KW'(PW * PW - 1);

    state_t        state;
    logic          kern;
    logic          hold;
    logic [KW-1:0] k;
    logic [DW-1:0] mx;
    logic          rd_st;
    logic          wl_st;
    logic [1:0]    phase;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] l1_addr;
    logic [AW-1:0] l2_addr;

    assign rd_st = state >= S_RD0 && state <= S_RD3;
    assign wl_st = state == S_WL1 || state == S_WL2;
    assign phase = 2'(state - S_RD0);

    cnn_pool_agu #(.AW(AW), .IMG_W(IMG_W), .KW(KW)) u_agu (
        .k       (k),
        .phase   (phase),
        .kern    (kern),
        .rd_addr (rd_addr),
        .l1_addr (l1_addr),
        .l2_addr (l2_addr)
    );

    // hold blocks re-triggering on a ready level that was already high when the run finished.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            kern  <= 1'b0;
            hold  <= 1'b0;
            k     <= '0;
            mx    <= '0;
        end else begin
            if (!ready)
                hold <= 1'b0;
            case (state)
                S_IDLE:
                    if (ready && !hold) begin
                        state <= S_START;
                        busy  <= 1'b1;
                        kern  <= 1'b0;
                    end
                S_START: state <= S_CONV;
                S_CONV:
                    if (conv_done) begin
                        state <= S_RD0;
                        k     <= '0;
                    end
                S_RD0, S_RD1, S_RD2, S_RD3: begin
                    mx    <= (state == S_RD0 || $signed(cdata_rd) > $signed(mx)) ? cdata_rd : mx;
                    state <= state + 4'd1;
                end
                S_WL1: state <= S_WL2;
                S_WL2:
                    if (k == LAST_K) begin
                        state <= kern ? S_DONE : S_START;
                        kern  <= 1'b1;
                    end else begin
                        k     <= k + 1'b1;
                        state <= S_RD0;
                    end
                S_DONE: begin
                    busy  <= 1'b0;
                    hold  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        conv_wr_gnt = state == S_CONV;
        conv_start  = state == S_START;
        conv_kernel = kern;
        crd         = rd_st;
        caddr_rd    = rd_st ? rd_addr : '0;
        cwr         = conv_wr_gnt ? conv_wr_req : wl_st;
        caddr_wr    = conv_wr_gnt ? conv_wr_addr : state == S_WL1 ? l1_addr : state == S_WL2 ? l2_addr : '0;
        cdata_wr    = conv_wr_gnt ? conv_wr_data : wl_st ? mx : '0;
        csel        = (conv_wr_gnt || rd_st) ? (kern ? CSEL_L0K1 : CSEL_L0K0) :
                      state == S_WL1 ? (kern ? CSEL_L1K1 : CSEL_L1K0) :
                      state == S_WL2 ? CSEL_L2 : CSEL_NONE;
    end

endmodule

// File: tb/tb_cnn_layer_sched.sv
// tb_cnn_layer_sched: directed bench with a banked memory model and a stub conv engine.
module tb_cnn_layer_sched;

    logic        clk = 1'b0;
    logic        reset, ready, conv_done, conv_wr_req;
    logic [11:0] conv_wr_addr;
    logic [19:0] conv_wr_data, cdata_rd;
    logic        busy, conv_start, conv_kernel, conv_wr_gnt, cwr, crd;
    logic [11:0] caddr_wr, caddr_rd;
    logic [19:0] cdata_wr;
    logic [2:0]  csel;

    logic        preload;
    logic [19:0] mem   [8][4096];
    logic [19:0] l0ref [2][4096];
    int passed = 0, total = 0, viol = 0, starts = 0;

    always #5 clk = ~clk;

    cnn_layer_sched dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .conv_start(conv_start), .conv_kernel(conv_kernel), .conv_done(conv_done),
        .conv_wr_req(conv_wr_req), .conv_wr_addr(conv_wr_addr), .conv_wr_data(conv_wr_data),
        .conv_wr_gnt(conv_wr_gnt), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int b = 0; b < 8; b++)
                for (int i = 0; i < 4096; i++)
                    mem[b][i] <= (b == 1) ? l0ref[0][i] : (b == 2) ? l0ref[1][i] : 20'h5A5A5;
        end else if (cwr) begin
            mem[csel][caddr_wr] <= cdata_wr;
        end
    end

    assign cdata_rd = crd ? mem[csel][caddr_rd] : 20'h0;

    always @(negedge clk) begin
        if (!reset) begin
            if (cwr && crd) viol++;
            if (cwr && !conv_wr_gnt && (csel == 3'd1 || csel == 3'd2)) viol++;
            if (conv_start) starts++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [19:0] win_max(input int kn, input int k);
        logic signed [19:0] m, v;
        int b;
        b = (k / 32) * 128 + (k % 32) * 2;
        m = l0ref[kn][b];
        v = l0ref[kn][b + 1];  if (v > m) m = v;
        v = l0ref[kn][b + 64]; if (v > m) m = v;
        v = l0ref[kn][b + 65]; if (v > m) m = v;
        return m;
    endfunction

    initial begin
        int n;
        int l1e [2];
        int l2e;
        reset = 1; ready = 1; conv_done = 0; conv_wr_req = 0;
        conv_wr_addr = 0; conv_wr_data = 0; preload = 1;
        for (int kn = 0; kn < 2; kn++)
            for (int i = 0; i < 4096; i++)
                l0ref[kn][i] = 20'($urandom);
        l0ref[0][0] = 20'd5;       l0ref[0][1] = 20'd9; l0ref[0][64] = 20'd3; l0ref[0][65] = 20'd7;
        l0ref[1][0] = 20'hFFFFF;   l0ref[1][1] = 20'd2; l0ref[1][64] = 20'd1; l0ref[1][65] = 20'd0;

        repeat (3) @(negedge clk);
        preload = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ctl", {conv_start, conv_kernel, cwr, crd, csel}, 0);
        chk("rst_addr", {caddr_rd, caddr_wr, cdata_wr}, 0);
        reset = 0;

        @(negedge clk); #1;
        chk("start0_busy", busy, 1);
        chk("start0_pulse", conv_start, 1);
        chk("start0_kern", conv_kernel, 0);
        chk("start0_gnt", conv_wr_gnt, 0);
        ready = 0;

        @(negedge clk);
        conv_wr_req = 1; conv_wr_addr = 12'h000; conv_wr_data = 20'h00010; #1;
        chk("start0_once", conv_start, 0);
        chk("conv_gnt", conv_wr_gnt, 1);
        chk("conv_cwr", cwr, 1);
        chk("conv_csel", csel, 3'b001);
        chk("conv_addr", caddr_wr, 12'h000);
        chk("conv_data", cdata_wr, 20'h00010);
        @(negedge clk); conv_wr_addr = 12'h000; conv_wr_data = 20'd5;
        @(negedge clk); conv_wr_addr = 12'h001; conv_wr_data = 20'd9;
        @(negedge clk); conv_wr_addr = 12'h040; conv_wr_data = 20'd3;
        @(negedge clk); conv_wr_addr = 12'h041; conv_wr_data = 20'd7;
        @(negedge clk); conv_wr_req = 0; conv_done = 1;

        @(negedge clk);
        conv_done = 0; conv_wr_req = 1; conv_wr_addr = 12'h555; conv_wr_data = 20'h7FFFF; #1;
        chk("rd0_crd", crd, 1);
        chk("rd0_addr", caddr_rd, 12'h000);
        chk("rd0_csel", csel, 3'b001);
        chk("rd0_no_cwr", cwr, 0);
        @(negedge clk); #1 chk("rd1_addr", caddr_rd, 12'h001);
        @(negedge clk); #1 chk("rd2_addr", caddr_rd, 12'h040);
        @(negedge clk); #1 chk("rd3_addr", caddr_rd, 12'h041);
        @(negedge clk); #1;
        chk("wl1_k0_ctl", {cwr, crd, csel}, {1'b1, 1'b0, 3'b011});
        chk("wl1_k0_addr", caddr_wr, 12'h000);
        chk("wl1_k0_data", cdata_wr, 20'd9);
        @(negedge clk); #1;
        chk("wl2_k0_csel", csel, 3'b101);
        chk("wl2_k0_addr", caddr_wr, 12'h000);
        chk("wl2_k0_data", cdata_wr, 20'd9);
        repeat (193) @(negedge clk);
        #1;
        chk("win33_crd", crd, 1);
        chk("win33_addr", caddr_rd, 12'h082);

        ready = 1;
        repeat (3) @(negedge clk);
        ready = 0;
        #1;
        n = 0;
        while (!conv_start && n < 8000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("start1_seen", conv_start, 1);
        chk("start1_kern", conv_kernel, 1);
        chk("start1_busy", busy, 1);

        @(negedge clk); conv_wr_addr = 12'h000; conv_wr_data = 20'hFFFFF; #1;
        chk("conv1_ctl", {cwr, csel}, {1'b1, 3'b010});
        @(negedge clk); conv_wr_addr = 12'h001; conv_wr_data = 20'd2;
        @(negedge clk); conv_wr_addr = 12'h040; conv_wr_data = 20'd1;
        @(negedge clk); conv_wr_addr = 12'h041; conv_wr_data = 20'd0;
        @(negedge clk); conv_wr_req = 0; conv_done = 1;
        @(negedge clk);
        conv_done = 0; conv_wr_req = 1; conv_wr_addr = 12'h555; conv_wr_data = 20'h7FFFF; #1;
        chk("rd0_k1", {crd, csel, caddr_rd}, {1'b1, 3'b010, 12'h000});
        repeat (4) @(negedge clk);
        #1;
        chk("wl1_k1_ctl", {cwr, csel}, {1'b1, 3'b100});
        chk("wl1_k1_addr", caddr_wr, 12'h000);
        chk("wl1_k1_data", cdata_wr, 20'd2);
        @(negedge clk); #1;
        chk("wl2_k1_csel", csel, 3'b101);
        chk("wl2_k1_addr", caddr_wr, 12'h001);
        chk("wl2_k1_data", cdata_wr, 20'd2);

        ready = 1;
        n = 0;
        while (busy && n < 7000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_busy", busy, 0);
        chk("no_conflicts", viol, 0);
        chk("two_starts", starts, 2);

        l1e[0] = 0; l1e[1] = 0; l2e = 0;
        for (int kn = 0; kn < 2; kn++)
            for (int k = 0; k < 1024; k++) begin
                if (mem[3 + kn][k] !== win_max(kn, k)) l1e[kn]++;
                if (mem[5][2 * k + kn] !== win_max(kn, k)) l2e++;
            end
        chk("l1k0_all", l1e[0], 0);
        chk("l1k1_all", l1e[1], 0);
        chk("l2_all", l2e, 0);

        repeat (5) @(negedge clk);
        #1;
        chk("held_ready_ignored", {busy, 8'(starts)}, {1'b0, 8'd2});

        ready = 0; conv_wr_req = 0;
        @(negedge clk);
        ready = 1;
        @(negedge clk); #1;
        chk("restart", {conv_start, conv_kernel, busy}, {1'b1, 1'b0, 1'b1});
        ready = 0;
        @(negedge clk); conv_done = 1;
        @(negedge clk); conv_done = 0; #1;
        chk("restart_rd0", {crd, caddr_rd}, {1'b1, 12'h000});
        repeat (602) @(negedge clk);
        #1;
        chk("rd2_k100", {crd, caddr_rd}, {1'b1, 12'h1C8});
        reset = 1;
        @(negedge clk); #1;
        chk("abort", {busy, crd, cwr}, 0);
        ready = 1;
        @(negedge clk);
        reset = 0;
        @(negedge clk); #1;
        chk("post_abort_start", {conv_start, conv_kernel}, {1'b1, 1'b0});
        @(negedge clk); conv_done = 1;
        @(negedge clk); conv_done = 0; #1;
        chk("post_abort_rd0", {crd, caddr_rd}, {1'b1, 12'h000});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
